threshold_fetch_ctrl: RTL and testbench

// - Sequencer for one block's threshold ROM. On start, reads NUM_THR packed thresholds from a

---
 rtl/threshold_fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_threshold_fetch_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/threshold_fetch_ctrl.sv
// ============================================================================
// Module   : threshold_fetch_ctrl
// Brief    : Fetches NUM_THR packed thresholds from a synchronous ROM, unpacks
//            them LSB field first and streams them over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module threshold_fetch_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int THR_WIDTH  = 8,
    parameter int NUM_THR    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  thr_valid,
    input  logic                  thr_ready,
    output logic [THR_WIDTH-1:0]  thr_data,
    output logic [((NUM_THR > 1) ? $clog2(NUM_THR) : 1)-1:0] thr_idx,
    output logic                  thr_last
);

    localparam int c_FIELDS = DATA_WIDTH / THR_WIDTH;
    localparam int c_FW     = (c_FIELDS > 1) ? $clog2(c_FIELDS) : 1;
    localparam int c_IW     = (NUM_THR > 1) ? $clog2(NUM_THR) : 1;

    localparam logic [c_FW-1:0] c_LAST_FIELD = c_FW'(c_FIELDS - 1);
    localparam logic [c_IW-1:0] c_LAST_IDX   = c_IW'(NUM_THR - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_READ  = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_SHIFT = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_word_cnt;
    logic [c_FW-1:0]       r_field;
    logic [c_IW-1:0]       r_idx;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  w_hs;

    assign w_hs = (r_state == c_SHIFT) && thr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // abort overrides every transition, including a start seen in IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_READ;
            c_READ:  w_next_state = c_WAIT;
            c_WAIT:  w_next_state = c_SHIFT;
            c_SHIFT: begin
                if (w_hs) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_next_state = c_DONE;
                    end else if (r_field == c_LAST_FIELD) begin
                        w_next_state = c_READ;
                    end
                end
            end
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
        if (abort) begin
            w_next_state = c_IDLE;
        end
    end

    always_comb begin
        busy      = (r_state != c_IDLE);
        done      = (r_state == c_DONE);
        rom_en    = (r_state == c_READ);
        rom_addr  = (r_state == c_READ) ? (r_base + r_word_cnt) : '0;
        thr_valid = (r_state == c_SHIFT);
        thr_data  = (r_state == c_SHIFT) ? r_word[r_field*THR_WIDTH +: THR_WIDTH] : '0;
        thr_idx   = (r_state == c_SHIFT) ? r_idx : '0;
        thr_last  = (r_state == c_SHIFT) && (r_idx == c_LAST_IDX);
    end

    // Datapath; an aborted WAIT never captures, so stale ROM data is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base     <= '0;
            r_word_cnt <= '0;
            r_field    <= '0;
            r_idx      <= '0;
            r_word     <= '0;
        end else if (!abort) begin
            if (r_state == c_IDLE && start) begin
                r_base     <= base_addr;
                r_word_cnt <= '0;
                r_field    <= '0;
                r_idx      <= '0;
            end
            if (r_state == c_WAIT) begin
                r_word <= rom_data;
            end
            if (w_hs) begin
                r_idx <= r_idx + 1'b1;
                if (r_field == c_LAST_FIELD) begin
                    r_field    <= '0;
                    r_word_cnt <= r_word_cnt + 1'b1;
                end else begin
                    r_field <= r_field + 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_threshold_fetch_ctrl.sv
// ============================================================================
// Module   : tb_threshold_fetch_ctrl
// Brief    : Table-driven scenario bench for threshold_fetch_ctrl with ROM
//            model and threshold / ROM-access scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_threshold_fetch_ctrl;

    localparam int LEN  = 24;
    localparam int NVEC = 9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  base_addr;
    logic        busy;
    logic        done;
    logic        rom_en;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        thr_valid;
    logic        thr_ready;
    logic [7:0]  thr_data;
    logic [2:0]  thr_idx;
    logic        thr_last;

    threshold_fetch_ctrl #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .THR_WIDTH  (8),
        .NUM_THR    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .thr_valid (thr_valid),
        .thr_ready (thr_ready),
        .thr_data  (thr_data),
        .thr_idx   (thr_idx),
        .thr_last  (thr_last)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [256];
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    typedef struct {
        logic [7:0] base;
        int rlo, rhi;
        int abort_c, start2_c, rst_c;
        int done_c, busy_end;
        int n_thr, n_rom;
        int rom_c0, rom_c1;
    } vec_t;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] idx;
        logic       last;
    } thr_t;

    typedef struct {
        int         cyc;
        logic [7:0] addr;
    } romx_t;

    vec_t  tbl [NVEC];
    thr_t  thr_q [$];
    romx_t rom_q [$];
    vec_t  t;
    thr_t  e;
    romx_t r;
    logic [31:0] w;
    int n_vec = 0;
    int n_err = 0;
    int cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
        rom[4]     = 32'h44332211;
        rom[5]     = 32'h88776655;
        rom[8'hFF] = 32'hDDCCBBAA;
        rom[0]     = 32'h04030201;
        rom_data   = 32'h0;

        //            base   rlo rhi abort st2 rst done bend nthr nrom r0 r1
        tbl[0] = '{8'h04, -1, -1, -1, -1, -1, 13, 13, 8, 2, 1, 7};   // plain fetch
        tbl[1] = '{8'h04,  4,  6, -1, -1, -1, 16, 16, 8, 2, 1, 10};  // backpressure
        tbl[2] = '{8'h04, -1, -1,  8, -1, -1, -1,  8, 4, 2, 1, 7};   // abort in WAIT
        tbl[3] = '{8'h04, -1, -1, -1, -1, -1, 13, 13, 8, 2, 1, 7};   // refetch after abort
        tbl[4] = '{8'h04, -1, -1, -1,  5, -1, 13, 13, 8, 2, 1, 7};   // start while busy
        tbl[5] = '{8'hFF, -1, -1, -1, -1, -1, 13, 13, 8, 2, 1, 7};   // address wrap
        tbl[6] = '{8'h04, -1, -1, -1, -1, 10, -1,  9, 5, 2, 1, 7};   // reset mid-fetch
        tbl[7] = '{8'h04, -1, -1, -1, -1, -1, 13, 13, 8, 2, 1, 7};   // fetch after reset
        tbl[8] = '{8'h04, -1, -1,  0, -1, -1, -1,  0, 0, 0, 1, 7};   // abort beats start

        cyc       = -1;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        thr_ready = 1'b1;
        base_addr = 8'h0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_outputs",
            {busy, done, rom_en, rom_addr, thr_valid, thr_data, thr_idx, thr_last}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);

        for (int v = 0; v < NVEC; v++) begin
            t = tbl[v];
            thr_q.delete();
            rom_q.delete();
            for (int i = 0; i < t.n_thr; i++) begin
                w      = rom[8'(t.base + 8'(i / 4))];
                e.data = w[(i % 4) * 8 +: 8];
                e.idx  = 3'(i);
                e.last = (i == 7);
                thr_q.push_back(e);
            end
            if (t.n_rom > 0) begin r.cyc = t.rom_c0; r.addr = t.base;        rom_q.push_back(r); end
            if (t.n_rom > 1) begin r.cyc = t.rom_c1; r.addr = t.base + 8'd1; rom_q.push_back(r); end

            for (int c = 0; c < LEN; c++) begin
                @(posedge clk);
                #1;
                cyc       = c;
                start     = (c == 0) || (c == t.start2_c);
                abort     = (c == t.abort_c);
                thr_ready = !(c >= t.rlo && c <= t.rhi);
                base_addr = t.base;
                rst_n     = (c != t.rst_c);
                #1;
                if (c == t.rst_c) begin
                    chk("rst_mid_outputs",
                        {busy, done, rom_en, rom_addr, thr_valid, thr_data, thr_idx, thr_last}, 32'h0);
                end else begin
                    chk("busy", busy, (c >= 1 && c <= t.busy_end));
                    chk("done", done, (c == t.done_c));
                    if (c == t.done_c) chk("valid_in_done", thr_valid, 1'b0);
                    if (rom_en) begin
                        if (rom_q.size() == 0) chk("rom_en_extra", rom_en, 1'b0);
                        else begin
                            r = rom_q.pop_front();
                            chk("rom_en_cycle", c, r.cyc);
                            chk("rom_addr", rom_addr, r.addr);
                        end
                    end
                    if (thr_valid) begin
                        if (thr_q.size() == 0) chk("thr_valid_extra", thr_valid, 1'b0);
                        else begin
                            e = thr_q[0];
                            chk("thr_data", thr_data, e.data);
                            chk("thr_idx", thr_idx, e.idx);
                            chk("thr_last", thr_last, e.last);
                            if (thr_ready) void'(thr_q.pop_front());
                        end
                    end
                end
            end
            chk("thr_left", thr_q.size(), 0);
            chk("rom_left", rom_q.size(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
